// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Brief    : Shared defaults, port index and request bundle for imem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Widest supported word address; imem_arbiter's AW must not exceed this.
  localparam int IMEM_AW = 6;
  localparam int IMEM_N  = 32;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DEBUG = 1'b1
  } imem_port_e;

  typedef struct packed {
    logic               valid;
    logic [IMEM_AW-1:0] addr;
  } imem_req_t;

  function automatic imem_port_e imem_other_port(input imem_port_e p);
    return (p == PORT_FETCH) ? PORT_DEBUG : PORT_FETCH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_arb_rsp_slot.sv
`default_nettype none
// ============================================================================
// Module   : imem_arb_rsp_slot
// Brief    : One-entry response register with load, flush and valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arb_rsp_slot
  import imem_pkg::*;
#(
  parameter int N = IMEM_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [N-1:0] i_load_data,
  input  logic         i_flush,
  input  logic         i_resp_ready,
  output logic         o_resp_valid,
  output logic [N-1:0] o_resp_data,
  output logic         o_free
);

  logic         r_valid;
  logic [N-1:0] r_data;

  // A flush frees the slot in the same cycle, like a consumer handshake would.
  assign o_free       = !r_valid || i_resp_ready || i_flush;
  assign o_resp_valid = r_valid;
  assign o_resp_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (i_resp_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Brief    : Shares one combinational ROM read port between fetch and debug.
//            Define IMEM_ARB_FETCH_PRIO_EN for fixed fetch priority with a
//            debug starvation limit; otherwise round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int N          = IMEM_N,
  parameter int AW         = IMEM_AW,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req_valid,
  output logic          f_req_ready,
  input  logic [AW-1:0] f_req_addr,
  output logic          f_resp_valid,
  input  logic          f_resp_ready,
  output logic [N-1:0]  f_resp_data,
  input  logic          f_flush,
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic [AW-1:0] d_req_addr,
  output logic          d_resp_valid,
  input  logic          d_resp_ready,
  output logic [N-1:0]  d_resp_data,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_q
);

  imem_req_t  w_f_req;
  imem_req_t  w_d_req;
  logic       w_f_free;
  logic       w_d_free;
  logic       w_f_elig;
  logic       w_d_elig;
  logic       w_f_gnt;
  logic       w_d_gnt;
  imem_port_e w_winner;

  assign w_f_req.valid = f_req_valid;
  assign w_f_req.addr  = IMEM_AW'(f_req_addr);
  assign w_d_req.valid = d_req_valid;
  assign w_d_req.addr  = IMEM_AW'(d_req_addr);

  // A flush cycle only retires the old fetch word; it never accepts a new one.
  assign w_f_elig = w_f_req.valid && w_f_free && !f_flush;
  assign w_d_elig = w_d_req.valid && w_d_free;

`ifdef IMEM_ARB_FETCH_PRIO_EN
  localparam int c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [c_CNT_W-1:0] r_starve;
  logic [c_CNT_W-1:0] w_starve_nxt;
  logic               w_starved;

  assign w_starved = (r_starve >= c_CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end

  // Saturates at the limit so the debug port keeps its claim until served.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_d_gnt) begin
      w_starve_nxt = '0;
    end else if (w_d_elig && !w_starved) begin
      w_starve_nxt = r_starve + c_CNT_W'(1);
    end
  end

  always_comb begin
    w_f_gnt  = 1'b0;
    w_d_gnt  = 1'b0;
    w_winner = PORT_FETCH;
    if (w_d_elig && (!w_f_elig || w_starved)) begin
      w_d_gnt  = 1'b1;
      w_winner = PORT_DEBUG;
    end else if (w_f_elig) begin
      w_f_gnt  = 1'b1;
    end
  end
`else
  imem_port_e r_prio;
  imem_port_e w_prio_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= PORT_FETCH;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

  // Priority passes to the loser only when someone was actually granted.
  always_comb begin
    w_prio_nxt = r_prio;
    if (w_f_gnt) begin
      w_prio_nxt = imem_other_port(PORT_FETCH);
    end else if (w_d_gnt) begin
      w_prio_nxt = imem_other_port(PORT_DEBUG);
    end
  end

  always_comb begin
    w_f_gnt  = 1'b0;
    w_d_gnt  = 1'b0;
    w_winner = PORT_FETCH;
    if (w_f_elig && (!w_d_elig || r_prio == PORT_FETCH)) begin
      w_f_gnt  = 1'b1;
    end else if (w_d_elig) begin
      w_d_gnt  = 1'b1;
      w_winner = PORT_DEBUG;
    end
  end
`endif

  assign f_req_ready = w_f_gnt;
  assign d_req_ready = w_d_gnt;
  assign mem_addr    = (w_winner == PORT_DEBUG) ? AW'(w_d_req.addr) : AW'(w_f_req.addr);

  imem_arb_rsp_slot #(
    .N (N)
  ) u_f_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_f_gnt),
    .i_load_data  (mem_q),
    .i_flush      (f_flush),
    .i_resp_ready (f_resp_ready),
    .o_resp_valid (f_resp_valid),
    .o_resp_data  (f_resp_data),
    .o_free       (w_f_free)
  );

  imem_arb_rsp_slot #(
    .N (N)
  ) u_d_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_d_gnt),
    .i_load_data  (mem_q),
    .i_flush      (1'b0),
    .i_resp_ready (d_resp_ready),
    .o_resp_valid (d_resp_valid),
    .o_resp_data  (d_resp_data),
    .o_free       (w_d_free)
  );

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Brief    : Self-checking bench for imem_arbiter against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int N  = 32;
  localparam int AW = 6;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req_valid, f_req_ready, f_resp_valid, f_resp_ready, f_flush;
  logic [AW-1:0] f_req_addr;
  logic [N-1:0]  f_resp_data;
  logic          d_req_valid, d_req_ready, d_resp_valid, d_resp_ready;
  logic [AW-1:0] d_req_addr;
  logic [N-1:0]  d_resp_data;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_q;

  logic [N-1:0]  rom [0:(1<<AW)-1];

  int passed = 0;
  int total  = 0;

  // Model: what each port's response slot holds, who has priority, starvation.
  bit           m_fv, m_dv, m_prio_d;
  logic [N-1:0] m_fd, m_dd;
  int           m_starve;
  bit           e_gf, e_gd, e_de;

  imem_arbiter #(.N(N), .AW(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_resp_valid(f_resp_valid), .f_resp_ready(f_resp_ready), .f_resp_data(f_resp_data),
    .f_flush(f_flush),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data),
    .mem_addr(mem_addr), .mem_q(mem_q)
  );

  assign mem_q = rom[mem_addr];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_fv = 0; m_dv = 0; m_fd = '0; m_dd = '0; m_prio_d = 0; m_starve = 0;
  endtask

  task automatic model_eval();
    bit ff, df, fe;
    ff   = !m_fv || f_resp_ready || f_flush;
    df   = !m_dv || d_resp_ready;
    fe   = f_req_valid && ff && !f_flush;
    e_de = d_req_valid && df;
    e_gf = 0;
    e_gd = 0;
`ifdef IMEM_ARB_FETCH_PRIO_EN
    if (fe && e_de) begin if (m_starve >= SM) e_gd = 1; else e_gf = 1; end
`else
    if (fe && e_de) begin if (m_prio_d) e_gd = 1; else e_gf = 1; end
`endif
    else if (fe) e_gf = 1;
    else if (e_de) e_gd = 1;
  endtask

  task automatic model_advance();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (f_flush) m_fv = 0;
      else if (e_gf) begin m_fv = 1; m_fd = rom[f_req_addr]; end
      else if (f_resp_ready) m_fv = 0;
      if (e_gd) begin m_dv = 1; m_dd = rom[d_req_addr]; end
      else if (d_resp_ready) m_dv = 0;
      if (e_gf) m_prio_d = 1;
      if (e_gd) m_prio_d = 0;
      if (e_gd) m_starve = 0;
      else if (e_de) m_starve++;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle_inputs();
    f_req_valid = 0; f_req_addr = '0; f_resp_ready = 1; f_flush = 0;
    d_req_valid = 0; d_req_addr = '0; d_resp_ready = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    f_req_valid = 1; f_req_addr = 6'd2;
    d_req_valid = 1; d_req_addr = 6'd3;
    model_reset();
    tick();
    tick();
    @(negedge clk);
    total++; if (f_resp_valid !== 1'b0) $display("FAIL reset_f_valid: got %b want 0", f_resp_valid); else passed++;
    total++; if (d_resp_valid !== 1'b0) $display("FAIL reset_d_valid: got %b want 0", d_resp_valid); else passed++;
    total++; if (f_resp_data !== '0) $display("FAIL reset_f_data: got %h want 0", f_resp_data); else passed++;
    total++; if (d_resp_data !== '0) $display("FAIL reset_d_data: got %h want 0", d_resp_data); else passed++;
    rst_n = 1;
    #1;
    total++; if (f_req_ready !== 1'b1) $display("FAIL first_f_ready: got %b want 1", f_req_ready); else passed++;
    total++; if (d_req_ready !== 1'b0) $display("FAIL first_d_ready: got %b want 0", d_req_ready); else passed++;
    tick();
    @(negedge clk);
    total++; if (f_resp_valid !== 1'b1) $display("FAIL first_f_valid: got %b want 1", f_resp_valid); else passed++;
    total++; if (f_resp_data !== 32'h40000113) $display("FAIL first_f_data: got %h want 40000113", f_resp_data); else passed++;
    tick();
  endtask

  task automatic test_stream();
    logic [N-1:0] exp_w [0:5];
    exp_w[0] = 32'h00003023; exp_w[1] = 32'h00000f93; exp_w[2] = 32'h40000113;
    exp_w[3] = rom[3]; exp_w[4] = rom[4]; exp_w[5] = rom[5];
    idle_inputs();
    tick();
    for (int i = 0; i <= 6; i++) begin
      f_req_valid = (i < 6);
      f_req_addr  = AW'(i);
      @(negedge clk);
      model_eval();
      if (i < 6) begin
        total++; if (f_req_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, f_req_ready); else passed++;
      end
      if (i > 0) begin
        total++; if (f_resp_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, f_resp_valid); else passed++;
        total++; if (f_resp_data !== exp_w[i-1]) $display("FAIL stream_data[%0d]: got %h want %h", i, f_resp_data, exp_w[i-1]); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic last_f;
    idle_inputs();
    tick();
    last_f = 1'b0;
    for (int i = 0; i < 12; i++) begin
      f_req_valid = 1; f_req_addr = AW'($urandom_range(0, 63));
      d_req_valid = 1; d_req_addr = AW'($urandom_range(0, 63));
      @(negedge clk);
      model_eval();
      total++; if (f_req_ready !== e_gf) $display("FAIL cont_f_ready[%0d]: got %b want %b", i, f_req_ready, e_gf); else passed++;
      total++; if (d_req_ready !== e_gd) $display("FAIL cont_d_ready[%0d]: got %b want %b", i, d_req_ready, e_gd); else passed++;
`ifndef IMEM_ARB_FETCH_PRIO_EN
      if (i > 0) begin
        total++; if (f_req_ready === last_f) $display("FAIL cont_alternate[%0d]: got f_req_ready %b twice", i, f_req_ready); else passed++;
      end
`endif
      last_f = f_req_ready;
      if (m_fv) begin
        total++; if (f_resp_data !== m_fd) $display("FAIL cont_f_data[%0d]: got %h want %h", i, f_resp_data, m_fd); else passed++;
      end
      if (m_dv) begin
        total++; if (d_resp_data !== m_dd) $display("FAIL cont_d_data[%0d]: got %h want %h", i, d_resp_data, m_dd); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    tick();
    d_resp_ready = 0; d_req_valid = 1; d_req_addr = 6'd7;
    tick();
    for (int i = 0; i < 5; i++) begin
      f_req_valid = 1; f_req_addr = AW'($urandom_range(0, 63));
      d_req_valid = 1; d_req_addr = AW'($urandom_range(0, 63));
      @(negedge clk);
      total++; if (d_req_ready !== 1'b0) $display("FAIL bp_d_ready[%0d]: got %b want 0", i, d_req_ready); else passed++;
      total++; if (d_resp_valid !== 1'b1) $display("FAIL bp_d_valid[%0d]: got %b want 1", i, d_resp_valid); else passed++;
      total++; if (d_resp_data !== rom[7]) $display("FAIL bp_d_data[%0d]: got %h want %h", i, d_resp_data, rom[7]); else passed++;
      total++; if (f_req_ready !== 1'b1) $display("FAIL bp_f_ready[%0d]: got %b want 1", i, f_req_ready); else passed++;
      total++; if (mem_addr !== f_req_addr) $display("FAIL bp_mem_addr[%0d]: got %h want %h", i, mem_addr, f_req_addr); else passed++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    tick();
    f_req_valid = 1; f_req_addr = 6'd10; f_resp_ready = 0;
    @(negedge clk);
    total++; if (f_req_ready !== 1'b1) $display("FAIL flush_load_ready: got %b want 1", f_req_ready); else passed++;
    tick();
    f_req_addr = 6'd11; f_flush = 1;
    @(negedge clk);
    total++; if (f_resp_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b want 1", f_resp_valid); else passed++;
    total++; if (f_req_ready !== 1'b0) $display("FAIL flush_cycle_ready: got %b want 0", f_req_ready); else passed++;
    tick();
    f_flush = 0;
    @(negedge clk);
    total++; if (f_resp_valid !== 1'b0) $display("FAIL flush_cleared: got %b want 0", f_resp_valid); else passed++;
    total++; if (f_req_ready !== 1'b1) $display("FAIL flush_after_ready: got %b want 1", f_req_ready); else passed++;
    tick();
    f_req_addr = 6'd12; f_flush = 1; f_resp_ready = 1;
    @(negedge clk);
    total++; if (f_resp_data !== rom[11]) $display("FAIL flush_after_data: got %h want %h", f_resp_data, rom[11]); else passed++;
    total++; if (f_req_ready !== 1'b0) $display("FAIL flush_ready_both: got %b want 0", f_req_ready); else passed++;
    tick();
    f_flush = 0; f_req_valid = 0;
    @(negedge clk);
    total++; if (f_resp_valid !== 1'b0) $display("FAIL flush_beats_ready: got %b want 0", f_resp_valid); else passed++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      f_req_valid  = ($urandom_range(0, 3) != 0);
      f_req_addr   = AW'($urandom);
      f_resp_ready = ($urandom_range(0, 3) != 0);
      f_flush      = ($urandom_range(0, 9) == 0);
      d_req_valid  = ($urandom_range(0, 1) != 0);
      d_req_addr   = AW'($urandom);
      d_resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_eval();
      total++; if (f_req_ready !== e_gf) $display("FAIL rnd_f_ready[%0d]: got %b want %b", i, f_req_ready, e_gf); else passed++;
      total++; if (d_req_ready !== e_gd) $display("FAIL rnd_d_ready[%0d]: got %b want %b", i, d_req_ready, e_gd); else passed++;
      total++; if (f_resp_valid !== m_fv) $display("FAIL rnd_f_valid[%0d]: got %b want %b", i, f_resp_valid, m_fv); else passed++;
      total++; if (d_resp_valid !== m_dv) $display("FAIL rnd_d_valid[%0d]: got %b want %b", i, d_resp_valid, m_dv); else passed++;
      if (m_fv) begin
        total++; if (f_resp_data !== m_fd) $display("FAIL rnd_f_data[%0d]: got %h want %h", i, f_resp_data, m_fd); else passed++;
      end
      if (m_dv) begin
        total++; if (d_resp_data !== m_dd) $display("FAIL rnd_d_data[%0d]: got %h want %h", i, d_resp_data, m_dd); else passed++;
      end
      if (e_gf || e_gd) begin
        total++;
        if (mem_addr !== (e_gd ? d_req_addr : f_req_addr))
          $display("FAIL rnd_mem_addr[%0d]: got %h want %h", i, mem_addr, e_gd ? d_req_addr : f_req_addr);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    f_req_valid = 1; f_req_addr = 6'd4; f_resp_ready = 0;
    d_req_valid = 1; d_req_addr = 6'd5; d_resp_ready = 0;
    tick();
    tick();
    rst_n = 0;
    #1;
    model_reset();
    total++; if (f_resp_valid !== 1'b0) $display("FAIL async_f_valid: got %b want 0", f_resp_valid); else passed++;
    total++; if (d_resp_valid !== 1'b0) $display("FAIL async_d_valid: got %b want 0", d_resp_valid); else passed++;
    total++; if (d_resp_data !== '0) $display("FAIL async_d_data: got %h want 0", d_resp_data); else passed++;
    @(negedge clk);
    rst_n = 1;
    #1;
    total++; if (f_req_ready !== 1'b1) $display("FAIL async_f_first: got %b want 1", f_req_ready); else passed++;
    tick();
    idle_inputs();
    tick();
  endtask

`ifdef IMEM_ARB_FETCH_PRIO_EN
  task automatic test_fixed_prio();
    rst_n = 0;
    idle_inputs();
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    f_req_valid = 1; d_req_valid = 1;
    for (int c = 1; c <= 12; c++) begin
      f_req_addr = AW'($urandom); d_req_addr = AW'($urandom);
      #1;
      total++; if (d_req_ready !== (c == SM + 1)) $display("FAIL prio_d_ready[%0d]: got %b want %b", c, d_req_ready, c == SM + 1); else passed++;
      total++; if (f_req_ready !== (c != SM + 1)) $display("FAIL prio_f_ready[%0d]: got %b want %b", c, f_req_ready, c != SM + 1); else passed++;
      tick();
      @(negedge clk);
    end
    idle_inputs();
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = (i < 48) ? ((32'h9E3779B9 * (i + 1)) ^ i) : '0;
    rom[0] = 32'h00003023;
    rom[1] = 32'h00000f93;
    rom[2] = 32'h40000113;
    test_reset();
    test_stream();
    test_contention();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
`ifdef IMEM_ARB_FETCH_PRIO_EN
    test_fixed_prio();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
